// File: rtl/axi_bfm_pkg.sv
// Shared types and fixed AXI attribute values for the AXI master arbiter.
package axi_bfm_pkg;

    // AXI response codes carried on BRESP / RRESP.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    // Every beat is a full 64-bit word on an incrementing burst of length one.
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Arbiter sequencing states; encodings are fixed so captured traces stay comparable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } arb_state_e;

endpackage

// File: rtl/axi_master_arbiter_if.sv
// AXI4 master-side channel bundle (single-beat subset) between the arbiter and the AXI slave.
//
// Handshake semantics on every channel here and on the req/rsp ports of the arbiter:
// a transfer happens on a rising clk edge where valid and ready are both high; once
// valid is raised it stays high with its payload stable until that edge; ready may
// rise or fall at any time and never depends on the same cycle's transfer having happened.
interface axi_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        output bready,
        input  bvalid, bresp,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        output rready,
        input  rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        input  bready,
        output bvalid, bresp,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        input  rready,
        output rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping around.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the last owner has lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between NUM_REQ single-beat requesters, one transaction at a time.
module axi_master_arbiter
    import axi_bfm_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 64,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output arb_state_e                dbg_state,
    axi_master_arbiter_if.master      axi
);

    localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

    arb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;

    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [STRB_W-1:0]   cmd_wstrb;
    logic                attr_on;
    logic                aw_done;
    logic                w_done;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                arvalid_q;
    logic                bready_q;
    logic                rready_q;

    logic                aw_hs;
    logic                w_hs;
    logic                aw_fin;
    logic                w_fin;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Route the winning requester's command slices to the capture registers.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Accept pulses only while idle; held low during reset so every output reads zero then.
    assign req_ready = (rst_n && (state == ST_IDLE)) ? gnt : '0;

    assign aw_hs  = awvalid_q & axi.awready;
    assign w_hs   = wvalid_q & axi.wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Fixed attributes read as zero until the first command has been captured after reset.
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = cmd_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = attr_on ? AXI_SIZE_8B : 3'b000;
    assign axi.awburst = attr_on ? AXI_BURST_INCR : 2'b00;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = cmd_wdata;
    assign axi.wstrb   = cmd_wstrb;
    assign axi.wlast   = attr_on;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = cmd_addr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = attr_on ? AXI_SIZE_8B : 3'b000;
    assign axi.arburst = attr_on ? AXI_BURST_INCR : 2'b00;
    assign axi.rready  = rready_q;

    // Transaction sequencer: grant, drive AXI channels, collect response, return it to the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            grant_id  <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wstrb <= '0;
            attr_on   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        grant_id  <= gnt_idx;
                        rr_ptr    <= gnt_idx;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        cmd_wstrb <= sel_wstrb;
                        attr_on   <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (sel_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, in either order or together.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q  <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_resp  <= axi.bresp;
                        rsp_valid <= REQ_ONE << grant_id;
                        state     <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        rready_q  <= 1'b0;
                        rsp_rdata <= axi.rdata;
                        rsp_resp  <= axi.rresp;
                        rsp_valid <= REQ_ONE << grant_id;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // Only the owning requester's ready retires the response.
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-beat reads must always carry RLAST; a missing one points at a misconfigured slave.
    assert property (@(posedge clk) disable iff (!rst_n) !(axi.rvalid && !axi.rlast));

endmodule
